// File: rtl/amba3_axi_rd_slave_mem_if.sv
// AXI3 read-address and read-data channel bundle for amba3_axi_rd_slave_mem.
// The slave modport is the memory's view; the master modport is the requester's.
interface amba3_axi_rd_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  // AR channel
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  // R channel
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/amba3_axi_rd_slave_mem.sv
// AXI3 read-channel responder backed by an internal word memory.
// Serves FIXED, INCR and WRAP bursts, one burst at a time, one beat per cycle.
// A side write port loads the memory; a write and a fetch of the same word at
// the same edge return the old word.
// Optional feature: define AMBA3_AXI_RD_SLAVE_DECERR_EN to answer beats that
// fall outside the memory window with DECERR instead of aliasing modulo size.
module amba3_axi_rd_slave_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                         aclk,
  input  logic                         areset,
  amba3_axi_rd_slave_mem_if.slave      axi,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LOG_NB = $clog2(NB);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Word index of a byte address; wraps modulo MEM_DEPTH by truncation.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> LOG_NB);
  endfunction

  // Address of the beat following 'a' for the given burst shape.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [3:0]            len,
    input logic [2:0]            size,
    input burst_type_t           burst
  );
    logic [ADDR_WIDTH-1:0] bytes, incr, wsz;
    bytes = A_ONE << size;
    incr  = (a & ~(bytes - A_ONE)) + bytes;
    wsz   = (ADDR_WIDTH'(len) + A_ONE) << size;
    case (burst)
      BURST_FIXED: return a;
      BURST_WRAP:  return (a & ~(wsz - A_ONE)) | (incr & (wsz - A_ONE));
      default:     return incr;
    endcase
  endfunction

`ifdef AMBA3_AXI_RD_SLAVE_DECERR_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(NB * MEM_DEPTH);

  // True when 'a' lies outside [BASE_ADDR, BASE_ADDR + memory size).
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return off[ADDR_WIDTH] || (off >= MEM_BYTES);
  endfunction
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Burst context
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            len_q;
  logic [2:0]            size_q;
  burst_type_t           burst_q;
  logic                  err_q;
  logic [3:0]            beat_q;

  // Registered channel outputs
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  resp_type_t            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Beat fetch controls produced by the FSM
  logic                  fetch;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_err;
  logic                  f_last;
  logic [3:0]            f_beat;
  resp_type_t            f_resp;
  logic [IDX_W-1:0]      f_idx;

  logic                  ar_err;
  logic [ADDR_WIDTH-1:0] ar_mask;
  logic                  ar_wrap;
  logic [ADDR_WIDTH-1:0] nxt_addr;

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rresp   = rresp_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;

  assign nxt_addr = next_addr(addr_q, len_q, size_q, burst_q);

  // Request legality, judged once on the AR payload.
  always_comb begin
    ar_mask = (A_ONE << axi.arsize) - A_ONE;
    ar_wrap = (axi.arburst == BURST_WRAP);
    ar_err  = (axi.arburst == BURST_RSVD)
           || (int'(axi.arsize) > LOG_NB)
           || (ar_wrap && !(axi.arlen == 4'd1 || axi.arlen == 4'd3 ||
                            axi.arlen == 4'd7 || axi.arlen == 4'd15))
           || (ar_wrap && ((axi.araddr & ar_mask) != '0));
  end

  // FSM next state and beat fetch selection.
  always_comb begin
    state_d = state_q;
    fetch   = 1'b0;
    f_addr  = addr_q;
    f_err   = err_q;
    f_last  = 1'b0;
    f_beat  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (axi.arvalid && arready_q) begin
          state_d = ST_BURST;
          fetch   = 1'b1;
          f_addr  = axi.araddr;
          f_err   = ar_err;
          f_last  = (axi.arlen == 4'd0);
          f_beat  = 4'd0;
        end
      end
      ST_BURST: begin
        if (rvalid_q && axi.rready) begin
          if (rlast_q) begin
            state_d = ST_IDLE;
          end else begin
            fetch  = 1'b1;
            f_addr = nxt_addr;
            f_last = ((beat_q + 4'd1) == len_q);
            f_beat = beat_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response code of the beat being fetched; SLVERR outranks DECERR.
  always_comb begin
    f_idx  = word_idx(f_addr);
    f_resp = RESP_OKAY;
    if (f_err) begin
      f_resp = RESP_SLVERR;
    end
`ifdef AMBA3_AXI_RD_SLAVE_DECERR_EN
    else if (out_of_range(f_addr)) begin
      f_resp = RESP_DECERR;
    end
`endif
  end

  // Side-port memory write; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // State, burst context and registered R channel.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      err_q     <= 1'b0;
      beat_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == ST_IDLE);
      if (state_q == ST_IDLE && state_d == ST_BURST) begin
        len_q   <= axi.arlen;
        size_q  <= axi.arsize;
        burst_q <= burst_type_t'(axi.arburst);
        err_q   <= ar_err;
        rid_q   <= axi.arid;
      end
      if (fetch) begin
        addr_q   <= f_addr;
        beat_q   <= f_beat;
        rlast_q  <= f_last;
        rresp_q  <= f_resp;
        rdata_q  <= (f_resp == RESP_OKAY) ? mem[f_idx] : '0;
        rvalid_q <= 1'b1;
      end else if (state_d == ST_IDLE) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_amba3_axi_rd_slave_mem.sv
// Directed bench for amba3_axi_rd_slave_mem: a table of bursts with
// hand-computed beats, plus sequences for stalls, write hazards and reset.
module tb_amba3_axi_rd_slave_mem;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        mem_we = 1'b0;
  logic [9:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;

  int nchk = 0;
  int nerr = 0;

  amba3_axi_rd_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi_if ();

  amba3_axi_rd_slave_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024), .BASE_ADDR(32'h0)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .axi      (axi_if),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    string            name;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic [3:0][31:0] d;
    logic [3:0][1:0]  r;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input string nm, input logic [31:0] a, input int len,
                              input int size, input int burst, input int id,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [1:0] r0, input logic [1:0] rn);
    vec_t v;
    v.name = nm; v.addr = a; v.len = 4'(len); v.size = 3'(size);
    v.burst = 2'(burst); v.id = 4'(id);
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.r[0] = r0; v.r[1] = rn; v.r[2] = rn; v.r[3] = rn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Present AR and wait (bounded) until it is accepted; returns at N+1.
  task automatic send_ar(input string nm, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
    int n;
    axi_if.araddr = a; axi_if.arlen = len; axi_if.arsize = size;
    axi_if.arburst = burst; axi_if.arid = id; axi_if.arvalid = 1'b1;
    n = 0;
    while (!axi_if.arready && n < 20) begin tick(); n++; end
    chk({nm, ".arready_wait"}, 32'(axi_if.arready), 32'd1);
    tick();
    axi_if.arvalid = 1'b0;
    chk({nm, ".arready_busy"}, 32'(axi_if.arready), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    axi_if.rready = 1'b1;
    send_ar(v.name, v.addr, v.len, v.size, v.burst, v.id);
    for (int b = 0; b <= int'(v.len); b++) begin
      chk($sformatf("%s.b%0d.rvalid", v.name, b), 32'(axi_if.rvalid), 32'd1);
      chk($sformatf("%s.b%0d.rdata", v.name, b), axi_if.rdata, v.d[b]);
      chk($sformatf("%s.b%0d.rresp", v.name, b), 32'(axi_if.rresp), 32'(v.r[b]));
      chk($sformatf("%s.b%0d.rid", v.name, b), 32'(axi_if.rid), 32'(v.id));
      chk($sformatf("%s.b%0d.rlast", v.name, b), 32'(axi_if.rlast), 32'(b == int'(v.len)));
      tick();
    end
    chk({v.name, ".idle_rvalid"}, 32'(axi_if.rvalid), 32'd0);
    chk({v.name, ".idle_arready"}, 32'(axi_if.arready), 32'd1);
  endtask

  localparam logic [1:0] OK = 2'b00, SLV = 2'b10, DEC = 2'b11;
  localparam int FX = 0, IN = 1, WR = 2, RS = 3;

  initial begin
    logic [1:0] edge_r1;
    logic [4:0] pat;
    int beats;
`ifdef AMBA3_AXI_RD_SLAVE_DECERR_EN
    edge_r1 = DEC;
`else
    edge_r1 = OK;
`endif
    tbl[0]  = mk("incr",     32'h10,  3, 2, IN, 5,  4, 5, 6, 7, OK, OK);
    tbl[1]  = mk("wrap4",    32'h38,  3, 2, WR, 3,  14, 15, 12, 13, OK, OK);
    tbl[2]  = mk("fixed",    32'h08,  2, 2, FX, 1,  2, 2, 2, 0, OK, OK);
    tbl[3]  = mk("rsvd",     32'h10,  1, 2, RS, 2,  0, 0, 0, 0, SLV, SLV);
    tbl[4]  = mk("wrap_len", 32'h00,  2, 2, WR, 4,  0, 0, 0, 0, SLV, SLV);
    tbl[5]  = mk("top_edge", 32'hFFC, 1, 2, IN, 6,  1023, 0, 0, 0, OK, edge_r1);
    tbl[6]  = mk("narrow",   32'h12,  1, 0, IN, 7,  4, 4, 0, 0, OK, OK);
    tbl[7]  = mk("bigsize",  32'h00,  0, 3, IN, 8,  0, 0, 0, 0, SLV, SLV);
    tbl[8]  = mk("wrap_una", 32'h3A,  1, 2, WR, 9,  0, 0, 0, 0, SLV, SLV);
    tbl[9]  = mk("wrap2",    32'h3C,  1, 2, WR, 10, 15, 14, 0, 0, OK, OK);
    tbl[10] = mk("incr_una", 32'h17,  2, 1, IN, 11, 5, 6, 6, 0, OK, OK);

    axi_if.arvalid = 1'b0; axi_if.rready = 1'b0;
    axi_if.araddr = '0; axi_if.arlen = '0; axi_if.arsize = '0;
    axi_if.arburst = '0; axi_if.arid = '0;

    // Reset state
    tick(); tick();
    chk("rst.arready", 32'(axi_if.arready), 32'd0);
    chk("rst.rvalid",  32'(axi_if.rvalid),  32'd0);
    chk("rst.rlast",   32'(axi_if.rlast),   32'd0);
    chk("rst.rresp",   32'(axi_if.rresp),   32'd0);
    chk("rst.rid",     32'(axi_if.rid),     32'd0);
    chk("rst.rdata",   axi_if.rdata,        32'd0);
    areset = 1'b0;
    tick();
    chk("rst.arready_up", 32'(axi_if.arready), 32'd1);

    // Preload mem[i] = i
    for (int i = 0; i < 1024; i++) begin
      mem_we = 1'b1; mem_addr = 10'(i); mem_wdata = 32'(i);
      tick();
    end
    mem_we = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // FIXED burst under rready 1,0,1,0,1: data held while stalled
    pat = 5'b10101;
    axi_if.rready = 1'b0;
    send_ar("stall", 32'h8, 4'd2, 3'd2, 2'(FX), 4'd1);
    beats = 0;
    for (int c = 0; c < 5; c++) begin
      axi_if.rready = pat[4-c];
      chk($sformatf("stall.c%0d.rvalid", c), 32'(axi_if.rvalid), 32'd1);
      chk($sformatf("stall.c%0d.rdata", c), axi_if.rdata, 32'd2);
      chk($sformatf("stall.c%0d.rlast", c), 32'(axi_if.rlast), 32'(beats == 2));
      tick();
      if (pat[4-c]) beats++;
    end
    chk("stall.done_rvalid", 32'(axi_if.rvalid), 32'd0);
    axi_if.rready = 1'b1;

    // Side-port write racing a fetch: same edge -> old word, earlier edge -> new word
    mem_we = 1'b1; mem_addr = 10'd17; mem_wdata = 32'hBBBB;
    tick();
    mem_addr = 10'd16; mem_wdata = 32'hAAAA;
    axi_if.araddr = 32'h40; axi_if.arlen = 4'd1; axi_if.arsize = 3'd2;
    axi_if.arburst = 2'(IN); axi_if.arid = 4'd2; axi_if.arvalid = 1'b1;
    chk("haz.arready", 32'(axi_if.arready), 32'd1);
    tick();
    mem_we = 1'b0; axi_if.arvalid = 1'b0;
    chk("haz.b0.rdata_old", axi_if.rdata, 32'd16);
    tick();
    chk("haz.b1.rdata_new", axi_if.rdata, 32'hBBBB);
    chk("haz.b1.rlast", 32'(axi_if.rlast), 32'd1);
    tick();
    send_ar("haz_rd", 32'h40, 4'd0, 3'd2, 2'(FX), 4'd2);
    chk("haz.rd.rdata", axi_if.rdata, 32'hAAAA);
    tick();

    // Reset during beat 2 of an 8-beat burst drops the burst
    send_ar("rstmid", 32'h0, 4'd7, 3'd2, 2'(IN), 4'hC);
    tick(); tick();
    chk("rstmid.b2.rdata", axi_if.rdata, 32'd2);
    areset = 1'b1;
    tick();
    chk("rstmid.rvalid", 32'(axi_if.rvalid), 32'd0);
    chk("rstmid.arready", 32'(axi_if.arready), 32'd0);
    chk("rstmid.rlast", 32'(axi_if.rlast), 32'd0);
    areset = 1'b0;
    tick();
    chk("rstmid.arready_up", 32'(axi_if.arready), 32'd1);
    chk("rstmid.no_beat", 32'(axi_if.rvalid), 32'd0);
    run_vec(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
